// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//   Instruction-memory fetch responder. After reset the whole word array is
//   filled with NOP_WORD, one word per cycle (CLEAR). The block then answers
//   fetch requests through a 2-entry in-order response FIFO (READY). A side
//   program-load port writes words while READY.
//
// Parameters
//   DEPTH      memory depth in 32-bit words (power of two, 16..4096)
//   NOP_WORD   fill word, also returned for erroneous fetches
//
// Ports
//   clock       single clock, rising edge
//   reset       synchronous active-low reset
//   req_valid   fetch request valid
//   req_ready   request can be accepted this cycle
//   req_addr    fetch byte address (PC)
//   resp_valid  response head valid
//   resp_ready  consumer takes the head response this cycle
//   resp_data   fetched instruction word
//   resp_err    fetch was misaligned or out of range
//   load_en     program-load write strobe
//   load_addr   program-load byte address
//   load_data   program-load word
//   busy        memory clear in progress
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            clr_we;

    logic [31:0]     mem_q [DEPTH];

    logic [31:0]     fifo_data_q [2];
    logic [1:0]      fifo_err_q;
    logic            fifo_head_q, fifo_head_d;
    logic [1:0]      fifo_count_q, fifo_count_d;
    logic            fifo_tail;

    logic            push, pop;

    // ------------------------------------------------------------------
    // Address decode. An address is legal only if word aligned and every
    // bit above the index field is zero, so large addresses never alias.
    // ------------------------------------------------------------------
    logic [AW-1:0]   fetch_idx, load_idx;
    logic            fetch_ok, load_ok, load_we;
    logic [31:0]     fetch_word;

    assign fetch_idx  = req_addr[AW+1:2];
    assign fetch_ok   = (req_addr[1:0] == 2'b00) && (req_addr[31:AW+2] == '0);
    assign fetch_word = fetch_ok ? mem_q[fetch_idx] : NOP_WORD;

    assign load_idx   = load_addr[AW+1:2];
    assign load_ok    = (load_addr[1:0] == 2'b00) && (load_addr[31:AW+2] == '0);
    assign load_we    = (state_q == READY) && load_en && load_ok;

    // ------------------------------------------------------------------
    // FSM next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_we    = 1'b0;
        busy      = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            CLEAR: begin
                busy      = 1'b1;
                clr_we    = 1'b1;
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                // Full FIFO blocks new requests even when a pop happens
                // this cycle; the freed slot is offered on the next cycle.
                req_ready = (fifo_count_q != 2'd2);
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response FIFO control
    // ------------------------------------------------------------------
    assign push      = req_valid && req_ready;
    assign pop       = resp_valid && resp_ready;
    assign fifo_tail = fifo_head_q ^ fifo_count_q[0];

    always_comb begin
        fifo_count_d = fifo_count_q;
        fifo_head_d  = fifo_head_q;
        if (pop) begin
            fifo_head_d = ~fifo_head_q;
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + 2'd1;
            2'b01:   fifo_count_d = fifo_count_q - 2'd1;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // Empty FIFO presents zeros so the outputs are defined after reset.
    assign resp_valid = (fifo_count_q != 2'd0);
    assign resp_data  = resp_valid ? fifo_data_q[fifo_head_q] : 32'h0;
    assign resp_err   = resp_valid & fifo_err_q[fifo_head_q];

    // ------------------------------------------------------------------
    // Control state registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!reset) begin
            state_q      <= CLEAR;
            clr_idx_q    <= '0;
            fifo_count_q <= 2'd0;
            fifo_head_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            fifo_count_q <= fifo_count_d;
            fifo_head_q  <= fifo_head_d;
        end
    end

    // FIFO payload: only meaningful under fifo_count_q, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data_q[fifo_tail] <= fetch_word;
            fifo_err_q[fifo_tail]  <= !fetch_ok;
        end
    end

    // ------------------------------------------------------------------
    // Instruction memory. Reads are combinational at the accepting edge,
    // so a same-cycle load to the fetched word returns the old contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset branch; it is initialised by the
        // CLEAR sweep instead, which keeps it mappable to RAM.
        if (clr_we) begin
            mem_q[clr_idx_q] <= NOP_WORD;
        end else if (load_we) begin
            mem_q[load_idx] <= load_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
//   Directed bench for imem_responder (DEPTH=256). A queue-based reference
//   model tracks memory contents, the remaining clear time and the pending
//   responses; a compare process checks the DUT against it on every falling
//   edge. Directed sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_imem_responder;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    imem_responder #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: memory image, cycles of clear left, response queue.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic [31:0] m_mem [DEPTH];
    resp_t       m_q [$];
    int          m_clear_left = 0;
    bit          m_known = 0;
    resp_t       m_r;
    bit          m_acc, m_pop;
    longint      m_idx;

    always @(posedge clock) begin
        if (reset === 1'b0) begin
            m_known      = 1;
            m_clear_left = DEPTH;
            m_q.delete();
            for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
        end else if (m_known) begin
            if (m_clear_left > 0) begin
                m_clear_left--;
            end else begin
                m_acc = (req_valid === 1'b1) && (m_q.size() < 2);
                m_pop = (m_q.size() > 0) && (resp_ready === 1'b1);
                m_idx = longint'(req_addr) / 4;
                if ((req_addr % 4) != 0 || m_idx >= DEPTH) begin
                    m_r.data = NOP;
                    m_r.err  = 1'b1;
                end else begin
                    m_r.data = m_mem[m_idx];
                    m_r.err  = 1'b0;
                end
                if (m_pop) void'(m_q.pop_front());
                if (m_acc) m_q.push_back(m_r);
                if (load_en === 1'b1 && (load_addr % 4) == 0 && (longint'(load_addr) / 4) < DEPTH)
                    m_mem[load_addr / 4] = load_data;
            end
        end
    end

    // Compare process: DUT against model on every falling edge.
    always @(negedge clock) begin
        if (m_known) begin
            check("busy", {31'b0, busy}, {31'b0, m_clear_left > 0});
            check("req_ready", {31'b0, req_ready},
                  {31'b0, (m_clear_left == 0) && (m_q.size() < 2)});
            check("resp_valid", {31'b0, resp_valid}, {31'b0, m_q.size() != 0});
            if (m_q.size() != 0) begin
                check("resp_data", resp_data, m_q[0].data);
                check("resp_err", {31'b0, resp_err}, {31'b0, m_q[0].err});
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse reset, check the reset state, then count the busy cycles.
    task automatic reset_and_clear();
        int n;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clock);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        n = 1;
        while (n < 1000) begin
            @(negedge clock);
            if (busy === 1'b0) break;
            n++;
        end
        load_en = 1'b0;
        check("clear_cycles", n, 32'd256);
        check("ready_after_clear", {31'b0, req_ready}, 32'd1);
        check("no_stale_resp", {31'b0, resp_valid}, 32'd0);
    endtask

    // Single fetch into an empty FIFO; response must appear one cycle later.
    task automatic fetch_expect(input string name, input logic [31:0] addr,
                                input logic [31:0] exp_data, input logic exp_err);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = addr;
        tick();
        req_valid  = 1'b0;
        @(negedge clock);
        check({name, "_valid"}, {31'b0, resp_valid}, 32'd1);
        check({name, "_data"}, resp_data, exp_data);
        check({name, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
        tick();
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached without finishing");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        resp_ready = 1'b0;
        load_en    = 1'b0;
        load_addr  = 32'h0;
        load_data  = 32'h0;

        // Power-up clear and first fetch of a cleared word.
        reset_and_clear();
        fetch_expect("fetch0_nop", 32'h0, NOP, 1'b0);

        // Program load, then back-to-back fetches.
        load_word(32'h0, 32'h0050_0093);
        load_word(32'h4, 32'h0010_8113);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h0;
        tick();
        req_addr   = 32'h4;
        @(negedge clock);
        check("b2b_first", resp_data, 32'h0050_0093);
        tick();
        req_valid  = 1'b0;
        @(negedge clock);
        check("b2b_second", resp_data, 32'h0010_8113);
        check("b2b_second_err", {31'b0, resp_err}, 32'd0);
        tick();

        // Backpressure: only two requests may be outstanding.
        begin
            int acc;
            acc        = 0;
            resp_ready = 1'b0;
            req_valid  = 1'b1;
            req_addr   = 32'h0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clock);
                if (req_ready === 1'b1) acc++;
                if (i >= 1) check("bp_head_stable", resp_data, 32'h0050_0093);
                tick();
                if (i == 0) req_addr = 32'h4;
            end
            check("bp_accepted", acc, 32'd2);
        end
        resp_ready = 1'b1;
        req_addr   = 32'h8;
        @(negedge clock);
        check("full_no_ready", {31'b0, req_ready}, 32'd0);
        check("drain_first", resp_data, 32'h0050_0093);
        @(negedge clock);
        check("drain_second", resp_data, 32'h0010_8113);
        tick();
        req_valid  = 1'b0;
        @(negedge clock);
        check("resume_data", resp_data, NOP);
        tick();

        // Error fetches and dropped loads.
        fetch_expect("misaligned", 32'h2, NOP, 1'b1);
        fetch_expect("out_of_range", 32'h400, NOP, 1'b1);
        fetch_expect("far_range", 32'h8000_0000, NOP, 1'b1);
        load_word(32'h401, 32'hFFFF_FFFF);
        load_word(32'h400, 32'h0BAD_0BAD);
        load_word(32'h1, 32'h1111_1111);
        fetch_expect("word0_intact", 32'h0, 32'h0050_0093, 1'b0);
        fetch_expect("word1_intact", 32'h4, 32'h0010_8113, 1'b0);

        // Same-cycle load and fetch of one word: old data first.
        resp_ready = 1'b1;
        load_en    = 1'b1;
        load_addr  = 32'h8;
        load_data  = 32'hDEAD_BEEF;
        req_valid  = 1'b1;
        req_addr   = 32'h8;
        tick();
        load_en    = 1'b0;
        req_valid  = 1'b0;
        @(negedge clock);
        check("rbw_old", resp_data, NOP);
        tick();
        fetch_expect("rbw_new", 32'h8, 32'hDEAD_BEEF, 1'b0);

        // Reset with two responses queued.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h0;
        tick();
        req_addr   = 32'h4;
        tick();
        req_valid  = 1'b0;
        @(negedge clock);
        check("queued_before_reset", {31'b0, resp_valid}, 32'd1);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clock);
        check("flush_valid", {31'b0, resp_valid}, 32'd0);
        check("flush_busy", {31'b0, busy}, 32'd1);

        // Reset again mid-clear; loads during clear must be ignored.
        repeat (100) tick();
        load_en   = 1'b1;
        load_addr = 32'h0;
        load_data = 32'h1234_5678;
        reset_and_clear();
        fetch_expect("recleared_w1", 32'h4, NOP, 1'b0);
        fetch_expect("recleared_w0", 32'h0, NOP, 1'b0);
        fetch_expect("recleared_w2", 32'h8, NOP, 1'b0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
